// File: rtl/laser_trip_detector.sv
// Debounced laser beam-break detector: hysteresis beam level, arming confirmation and trip debounce.
// Optional sample-stream watchdog enabled by defining LASER_TRIP_WATCHDOG_EN.
module laser_trip_detector #(
   parameter int DATA_W      = 12,
   parameter int THRESH_LO   = 1200,
   parameter int THRESH_HI   = 1800,
   parameter int ARM_COUNT   = 8,
   parameter int TRIP_COUNT  = 4,
   parameter int WDOG_CYCLES = 50000
) (
   input  logic              clock,
   input  logic              rst,
   input  logic [DATA_W-1:0] sample,
   input  logic              sample_valid,
   input  logic              arm,
   output logic              laser_triggered,
   output logic              armed,
   output logic              beam_present,
   output logic              fault,
   output logic [1:0]        state_dbg
);

   localparam int ARM_W = $clog2(ARM_COUNT + 1);
   localparam int LOW_W = $clog2(TRIP_COUNT + 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMING  = 2'd1,
      WATCH   = 2'd2,
      TRIPPED = 2'd3
   } state_t;

   state_t           state, state_nxt;
   logic [ARM_W-1:0] arm_cnt, arm_cnt_nxt;
   logic [LOW_W-1:0] low_cnt, low_cnt_nxt;
   logic             lit, dark;
   logic             wdog_flag;

   assign lit       = (sample >= DATA_W'(THRESH_HI));
   assign dark      = (sample <  DATA_W'(THRESH_LO));
   assign state_dbg = state;

`ifdef LASER_TRIP_WATCHDOG_EN
   localparam int WD_W = $clog2(WDOG_CYCLES + 1);

   logic [WD_W-1:0] wdog_cnt;
   logic            wdog_hit;

   assign wdog_hit  = (wdog_cnt == WD_W'(WDOG_CYCLES));
   // A stall counts as soon as the limit is reached, so WATCH trips on the same edge fault sets.
   assign wdog_flag = fault | wdog_hit;

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         wdog_cnt <= '0;
         fault    <= 1'b0;
      end else begin
         if (sample_valid)
            wdog_cnt <= '0;
         else if (!wdog_hit)
            wdog_cnt <= wdog_cnt + WD_W'(1);
         if (!arm)
            fault <= 1'b0;
         else if (wdog_hit && state != IDLE)
            fault <= 1'b1;
      end
   end
`else
   assign fault     = 1'b0;
   assign wdog_flag = 1'b0;
`endif

   always_comb begin
      state_nxt   = state;
      arm_cnt_nxt = arm_cnt;
      low_cnt_nxt = low_cnt;
      if (!arm) begin
         // Disarm overrides everything, including a final dark sample on the same cycle.
         state_nxt   = IDLE;
         arm_cnt_nxt = '0;
         low_cnt_nxt = '0;
      end else begin
         case (state)
            IDLE: begin
               state_nxt   = ARMING;
               arm_cnt_nxt = '0;
            end
            ARMING: begin
               if (sample_valid) begin
                  if (lit) begin
                     if (arm_cnt != ARM_W'(ARM_COUNT))
                        arm_cnt_nxt = arm_cnt + ARM_W'(1);
                     if (arm_cnt >= ARM_W'(ARM_COUNT - 1) && !wdog_flag) begin
                        state_nxt   = WATCH;
                        low_cnt_nxt = '0;
                     end
                  end else begin
                     arm_cnt_nxt = '0;
                  end
               end
            end
            WATCH: begin
               if (wdog_flag) begin
                  state_nxt = TRIPPED;
               end else if (sample_valid) begin
                  if (dark) begin
                     if (low_cnt != LOW_W'(TRIP_COUNT))
                        low_cnt_nxt = low_cnt + LOW_W'(1);
                     if (low_cnt >= LOW_W'(TRIP_COUNT - 1))
                        state_nxt = TRIPPED;
                  end else begin
                     // Band samples also clear the debounce, not only lit ones.
                     low_cnt_nxt = '0;
                  end
               end
            end
            TRIPPED: state_nxt = TRIPPED;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         state           <= IDLE;
         arm_cnt         <= '0;
         low_cnt         <= '0;
         laser_triggered <= 1'b0;
         armed           <= 1'b0;
         beam_present    <= 1'b0;
      end else begin
         state           <= state_nxt;
         arm_cnt         <= arm_cnt_nxt;
         low_cnt         <= low_cnt_nxt;
         laser_triggered <= (state_nxt == TRIPPED);
         armed           <= (state_nxt == WATCH);
         if (sample_valid) begin
            if (lit)
               beam_present <= 1'b1;
            else if (dark)
               beam_present <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_laser_trip_detector.sv
// Directed bench for laser_trip_detector: vector table for the main flow, hand sequences for
// asynchronous reset, single-sample trip and sample-stream stall.
module tb_laser_trip_detector;

   logic        clock = 1'b0;
   logic        rst = 1'b0;
   logic [11:0] sample = '0;
   logic        sample_valid = 1'b0;
   logic        arm = 1'b0;
   logic        laser_triggered, armed, beam_present, fault;
   logic [1:0]  state_dbg;
   logic        t1_trig, t1_armed, t1_beam, t1_fault;
   logic [1:0]  t1_state;

   int total = 0;
   int bad = 0;

   typedef struct {
      logic        valid;
      logic [11:0] smp;
      logic        arm;
      logic [1:0]  st;
      logic        trig;
      logic        armd;
      logic        beam;
   } vec_t;

   vec_t vecs[$];

   laser_trip_detector dut (
      .clock(clock), .rst(rst), .sample(sample), .sample_valid(sample_valid), .arm(arm),
      .laser_triggered(laser_triggered), .armed(armed), .beam_present(beam_present),
      .fault(fault), .state_dbg(state_dbg)
   );

   laser_trip_detector #(.ARM_COUNT(1), .TRIP_COUNT(1)) dut_t1 (
      .clock(clock), .rst(rst), .sample(sample), .sample_valid(sample_valid), .arm(arm),
      .laser_triggered(t1_trig), .armed(t1_armed), .beam_present(t1_beam),
      .fault(t1_fault), .state_dbg(t1_state)
   );

   always #10 clock = ~clock;

   task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got={st,trig,armed,beam,fault}=%b want=%b", name, act, exp);
      end
   endtask

   function automatic logic [5:0] outs();
      return {state_dbg, laser_triggered, armed, beam_present, fault};
   endfunction

   task automatic drive(input logic v, input logic [11:0] s, input logic a);
      sample_valid = v;
      sample       = s;
      arm          = a;
      @(posedge clock);
      #1;
   endtask

   task automatic add(input logic v, input int s, input logic a, input logic [1:0] st,
                      input logic t, input logic ar, input logic b);
      vec_t x;
      x.valid = v; x.smp = 12'(s); x.arm = a; x.st = st; x.trig = t; x.armd = ar; x.beam = b;
      vecs.push_back(x);
   endtask

   initial begin
      // Arm and confirm the beam with 8 lit samples.
      add(0, 0, 1, 2'd1, 0, 0, 0);
      repeat (7) add(1, 2000, 1, 2'd1, 0, 0, 1);
      add(1, 2000, 1, 2'd2, 0, 1, 1);
      // Four dark samples, strobes three clocks apart.
      for (int i = 0; i < 3; i++) begin
         add(1, 500, 1, 2'd2, 0, 1, 0);
         add(0, 0, 1, 2'd2, 0, 1, 0);
         add(0, 0, 1, 2'd2, 0, 1, 0);
      end
      add(1, 500, 1, 2'd3, 1, 0, 0);
      add(1, 2000, 1, 2'd3, 1, 0, 1);
      add(1, 2000, 1, 2'd3, 1, 0, 1);
      add(0, 0, 0, 2'd0, 0, 0, 1);
      // Re-arm, then a band sample mid-debounce restarts the count.
      add(0, 0, 1, 2'd1, 0, 0, 1);
      repeat (7) add(1, 2000, 1, 2'd1, 0, 0, 1);
      add(1, 2000, 1, 2'd2, 0, 1, 1);
      repeat (3) add(1, 500, 1, 2'd2, 0, 1, 0);
      add(1, 1500, 1, 2'd2, 0, 1, 0);
      repeat (3) add(1, 500, 1, 2'd2, 0, 1, 0);
      add(1, 500, 1, 2'd3, 1, 0, 0);
      add(0, 0, 0, 2'd0, 0, 0, 0);
      // A band sample during ARMING restarts the lit count.
      add(0, 0, 1, 2'd1, 0, 0, 0);
      repeat (5) add(1, 2000, 1, 2'd1, 0, 0, 1);
      add(1, 1700, 1, 2'd1, 0, 0, 1);
      repeat (7) add(1, 2000, 1, 2'd1, 0, 0, 1);
      add(1, 2000, 1, 2'd2, 0, 1, 1);
      // Exact threshold edges.
      add(1, 1199, 1, 2'd2, 0, 1, 0);
      add(1, 1200, 1, 2'd2, 0, 1, 0);
      add(1, 1799, 1, 2'd2, 0, 1, 0);
      add(1, 1800, 1, 2'd2, 0, 1, 1);
      repeat (3) add(1, 1199, 1, 2'd2, 0, 1, 0);
      // Disarm on the final dark sample wins over the trip.
      add(1, 1199, 0, 2'd0, 0, 0, 0);
      add(0, 0, 1, 2'd1, 0, 0, 0);
      add(1, 2000, 1, 2'd1, 0, 0, 1);

      // Reset state.
      repeat (2) @(posedge clock);
      #1;
      check("reset_hold", outs(), 6'b000000);
      rst = 1'b1;
      #1;
      check("reset_release", outs(), 6'b000000);

      foreach (vecs[i]) begin
         drive(vecs[i].valid, vecs[i].smp, vecs[i].arm);
         check($sformatf("vec%0d", i), outs(),
               {vecs[i].st, vecs[i].trig, vecs[i].armd, vecs[i].beam, 1'b0});
      end

      // Asynchronous reset in the middle of a debounce.
      repeat (7) drive(1, 12'd2000, 1);
      check("rst_seq_armed", outs(), 6'b10_0_1_1_0);
      repeat (3) drive(1, 12'd500, 1);
      check("rst_seq_low3", outs(), 6'b10_0_1_0_0);
      #3 rst = 1'b0;
      #1;
      check("async_reset", outs(), 6'b000000);
      @(posedge clock);
      #1 rst = 1'b1;
      drive(0, 12'd0, 1);
      repeat (7) drive(1, 12'd2000, 1);
      check("rearm_7_lit", outs(), 6'b01_0_0_1_0);
      drive(1, 12'd2000, 1);
      check("rearm_8_lit", outs(), 6'b10_0_1_1_0);
      repeat (3) drive(1, 12'd500, 1);
      check("fresh_low3", outs(), 6'b10_0_1_0_0);
      drive(1, 12'd500, 1);
      check("fresh_trip", outs(), 6'b11_1_0_0_0);

      // Single-sample confirm and trip with ARM_COUNT=1, TRIP_COUNT=1.
      drive(0, 12'd0, 0);
      drive(0, 12'd0, 1);
      drive(1, 12'd2000, 1);
      check("t1_armed", {t1_state, t1_trig, t1_armed, t1_beam, t1_fault}, 6'b10_0_1_1_0);
      drive(1, 12'd500, 1);
      check("t1_trip", {t1_state, t1_trig, t1_armed, t1_beam, t1_fault}, 6'b11_1_0_0_0);

      // Sample stream stalls while watching.
      drive(0, 12'd0, 0);
      drive(0, 12'd0, 1);
      repeat (8) drive(1, 12'd2000, 1);
      check("stall_start", outs(), 6'b10_0_1_1_0);
      repeat (50005) drive(0, 12'd0, 1);
`ifdef LASER_TRIP_WATCHDOG_EN
      check("stall_fault", outs(), 6'b11_1_0_1_1);
`else
      check("stall_no_fault", outs(), 6'b10_0_1_1_0);
`endif
      drive(0, 12'd0, 0);
      check("stall_disarm", outs(), 6'b00_0_0_1_0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
